exe_hazard_scoreboard: RTL and testbench

- Tracks the up-to-three instructions in flight in the 3-cycle EXE stage: ALU, MEM and VDOT ops, which produce results at different cycles.
- For each instruction in ID it decides one of three outcomes per source operand: read the register file, forward from a specific EXE slot, or stall ID and insert a bubble.
- Sits beside the ID/EX pipeline register and drives the ID stall and the forwarding-mux selects.
- It is the scheduling brain for the hazard outputs of the EXE stage.

---
 rtl/exe_hazard_scoreboard.sv | 130 +++++++++++++
 tb/tb_exe_hazard_scoreboard.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/exe_hazard_scoreboard.sv
// EXE-stage hazard scoreboard.
// Tracks the three instructions in the EXE stage: slot0 is the youngest and
// slot2 the oldest. For each source operand of the instruction in ID it picks
// one of three actions: read the register file, forward from an EXE slot, or
// stall ID.
// The EXE stage never stalls, so the slots shift on every edge. A stalled or
// flushed ID instruction enters slot0 as an all-zero bubble.
module exe_hazard_scoreboard #(
  parameter int MEM_LAT  = 1,
  parameter int VDOT_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic             issue_regWrite,
  input  logic [1:0]       issue_op,
  input  logic             flush,
  input  logic [4:0]       rs1Addr_ID,
  input  logic [4:0]       rs2Addr_ID,
  input  logic             rs1_used,
  input  logic             rs2_used,
  output logic             stall_ID,
  output logic [1:0]       fwd_sel_rs1,
  output logic [1:0]       fwd_sel_rs2,
  output logic [1:0]       inflight_cnt,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] OP_MEM  = 2'd1;
  localparam logic [1:0] OP_VDOT = 2'd2;

  // Per-slot state. Index 0 is the youngest slot.
  logic [2:0]      r_valid;
  logic [2:0][4:0] r_rd;
  logic [2:0]      r_rw;
  logic [2:0][1:0] r_op;
  logic [1:0]      r_inflight;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_hit1, w_hit2;
  logic [1:0] w_idx1, w_idx2;
  logic       w_rdy1, w_rdy2;
  logic       w_new_valid;

  // An op in slot k has its result ready when k is at or past its latency.
  // ALU ops and the reserved op 3 are ready in every slot.
  function automatic logic slot_ready(input logic [1:0] k, input logic [1:0] op);
    logic rdy;
    case (op)
      OP_MEM:  rdy = (k >= 2'(MEM_LAT));
      OP_VDOT: rdy = (k >= 2'(VDOT_LAT));
      default: rdy = 1'b1;
    endcase
    return rdy;
  endfunction

  // Find the youngest matching producer for each source. The loop runs from
  // the oldest slot to the youngest, so a younger match overwrites an older
  // one. x0 never matches.
  always_comb begin
    w_hit1 = 1'b0;
    w_idx1 = 2'd0;
    w_hit2 = 1'b0;
    w_idx2 = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (r_valid[k] && r_rw[k] && (r_rd[k] != 5'd0)) begin
        if (rs1_used && (r_rd[k] == rs1Addr_ID)) begin
          w_hit1 = 1'b1;
          w_idx1 = 2'(k);
        end
        if (rs2_used && (r_rd[k] == rs2Addr_ID)) begin
          w_hit2 = 1'b1;
          w_idx2 = 2'(k);
        end
      end
    end
  end

  // Forward only from the youngest producer. If that producer is not ready,
  // ID must stall; an older match would hold stale data and is never used.
  always_comb begin
    w_rdy1      = slot_ready(w_idx1, r_op[w_idx1]);
    w_rdy2      = slot_ready(w_idx2, r_op[w_idx2]);
    fwd_sel_rs1 = (w_hit1 && w_rdy1) ? 2'(w_idx1 + 2'd1) : 2'd0;
    fwd_sel_rs2 = (w_hit2 && w_rdy2) ? 2'(w_idx2 + 2'd1) : 2'd0;
    stall_ID    = issue_valid && !flush &&
                  ((w_hit1 && !w_rdy1) || (w_hit2 && !w_rdy2));
    w_new_valid = issue_valid && !stall_ID && !flush;
  end

  // Shift the slots on every edge. A rejected entry enters as an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_rd    <= '0;
      r_rw    <= '0;
      r_op    <= '0;
    end else begin
      r_valid <= {r_valid[1], r_valid[0], w_new_valid};
      r_rd    <= {r_rd[1], r_rd[0], (w_new_valid ? issue_rd : 5'd0)};
      r_rw    <= {r_rw[1], r_rw[0], (w_new_valid & issue_regWrite)};
      r_op    <= {r_op[1], r_op[0], (w_new_valid ? issue_op : 2'd0)};
    end
  end

  // Count the valid slots that will exist after this edge. After the shift,
  // the old slot2 has left the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 2'd0;
    end else begin
      r_inflight <= {1'b0, w_new_valid} + {1'b0, r_valid[0]} + {1'b0, r_valid[1]};
    end
  end

  // Count stall cycles. The counter saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall_ID && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign inflight_cnt = r_inflight;
  assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_exe_hazard_scoreboard.sv
// Directed bench for exe_hazard_scoreboard.
// Inputs change 1 ns after the rising edge. Combinational outputs are sampled
// while those inputs are stable. The stall counter is made narrow so that
// saturation can be reached quickly.
module tb_exe_hazard_scoreboard;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic          issue_regWrite;
  logic [1:0]    issue_op;
  logic          flush;
  logic [4:0]    rs1Addr_ID;
  logic [4:0]    rs2Addr_ID;
  logic          rs1_used;
  logic          rs2_used;
  logic          stall_ID;
  logic [1:0]    fwd_sel_rs1;
  logic [1:0]    fwd_sel_rs2;
  logic [1:0]    inflight_cnt;
  logic [CW-1:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  exe_hazard_scoreboard #(.MEM_LAT(1), .VDOT_LAT(2), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_regWrite (issue_regWrite),
    .issue_op       (issue_op),
    .flush          (flush),
    .rs1Addr_ID     (rs1Addr_ID),
    .rs2Addr_ID     (rs2Addr_ID),
    .rs1_used       (rs1_used),
    .rs2_used       (rs2_used),
    .stall_ID       (stall_ID),
    .fwd_sel_rs1    (fwd_sel_rs1),
    .fwd_sel_rs2    (fwd_sel_rs2),
    .inflight_cnt   (inflight_cnt),
    .stall_cycles   (stall_cycles)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Set up the instruction in ID. An rs value of 0 with used=0 means unused.
  task automatic drive_id(input logic v, input logic [4:0] rd, input logic rw,
                          input logic [1:0] op, input logic [4:0] s1, input logic u1,
                          input logic [4:0] s2, input logic u2);
    issue_valid    = v;
    issue_rd       = rd;
    issue_regWrite = rw;
    issue_op       = op;
    rs1Addr_ID     = s1;
    rs1_used       = u1;
    rs2Addr_ID     = s2;
    rs2_used       = u2;
    #1;
  endtask

  task automatic idle();
    drive_id(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    idle();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_inflight", 32'(inflight_cnt), 0);
    check("rst_stallcnt", 32'(stall_cycles), 0);
    drive_id(1'b0, 5'd0, 1'b0, 2'd0, 5'd5, 1'b1, 5'd0, 1'b0);
    check("rst_stall", 32'(stall_ID), 0);
    check("rst_fwd1", 32'(fwd_sel_rs1), 0);

    // ALU x5, then dependent readers in the next two cycles
    drive_id(1'b1, 5'd5, 1'b1, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    check("alu_inflight", 32'(inflight_cnt), 1);
    drive_id(1'b1, 5'd0, 1'b0, 2'd0, 5'd5, 1'b1, 5'd0, 1'b0);
    check("alu_stall", 32'(stall_ID), 0);
    check("alu_fwd_s0", 32'(fwd_sel_rs1), 1);
    step();
    check("alu_fwd_s1", 32'(fwd_sel_rs1), 2);
    check("alu_inflight2", 32'(inflight_cnt), 2);
    drain();
    check("drained", 32'(inflight_cnt), 0);

    // Load-use: the consumer stalls for one cycle
    drive_id(1'b1, 5'd6, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    drive_id(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 5'd6, 1'b1);
    check("ld_stall", 32'(stall_ID), 1);
    check("ld_fwd2_wait", 32'(fwd_sel_rs2), 0);
    step();
    check("ld_stall_end", 32'(stall_ID), 0);
    check("ld_fwd2", 32'(fwd_sel_rs2), 2);
    check("ld_stallcnt", 32'(stall_cycles), 1);
    check("ld_bubble", 32'(inflight_cnt), 1);
    step();
    drain();

    // VDOT into a dependent consumer: two stall cycles
    drive_id(1'b1, 5'd7, 1'b1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    drive_id(1'b1, 5'd0, 1'b0, 2'd0, 5'd7, 1'b1, 5'd0, 1'b0);
    check("vd_stall0", 32'(stall_ID), 1);
    step();
    check("vd_stall1", 32'(stall_ID), 1);
    check("vd_fwd_wait", 32'(fwd_sel_rs1), 0);
    check("vd_bubble1", 32'(inflight_cnt), 1);
    step();
    check("vd_stall_end", 32'(stall_ID), 0);
    check("vd_fwd1", 32'(fwd_sel_rs1), 3);
    check("vd_stallcnt", 32'(stall_cycles), 3);
    check("vd_bubble2", 32'(inflight_cnt), 1);
    step();
    drain();

    // Two writers of x8: the youngest one wins. x0 and unused sources never match.
    drive_id(1'b1, 5'd8, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    drive_id(1'b1, 5'd8, 1'b1, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    drive_id(1'b1, 5'd0, 1'b0, 2'd0, 5'd8, 1'b1, 5'd8, 1'b0);
    check("dual_fwd1", 32'(fwd_sel_rs1), 1);
    check("dual_stall", 32'(stall_ID), 0);
    check("unused_fwd2", 32'(fwd_sel_rs2), 0);
    drive_id(1'b1, 5'd0, 1'b1, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    drive_id(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b1, 5'd8, 1'b1);
    check("x0_fwd1", 32'(fwd_sel_rs1), 0);
    check("x8_slot1_fwd2", 32'(fwd_sel_rs2), 2);
    check("x0_stall", 32'(stall_ID), 0);
    check("three_inflight", 32'(inflight_cnt), 3);
    drain();

    // A younger load that is not ready hides an older ready ALU result
    drive_id(1'b1, 5'd9, 1'b1, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    drive_id(1'b1, 5'd9, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    drive_id(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 5'd9, 1'b1);
    check("stale_stall", 32'(stall_ID), 1);
    check("stale_fwd2", 32'(fwd_sel_rs2), 0);
    drive_id(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 5'd9, 1'b1);
    check("novalid_stall", 32'(stall_ID), 0);
    drain();
    check("stallcnt_kept", 32'(stall_cycles), 3);

    // Flush: the issue is squashed and the stall is suppressed
    drive_id(1'b1, 5'd12, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    drive_id(1'b1, 5'd11, 1'b1, 2'd0, 5'd12, 1'b1, 5'd0, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_stall", 32'(stall_ID), 0);
    step();
    flush = 1'b0;
    check("flush_inflight", 32'(inflight_cnt), 1);
    check("flush_stallcnt", 32'(stall_cycles), 3);
    drive_id(1'b1, 5'd0, 1'b0, 2'd0, 5'd11, 1'b1, 5'd0, 1'b0);
    check("flush_no_x11", 32'(fwd_sel_rs1), 0);
    drain();

    // Reset mid-operation with a VDOT in slot1
    drive_id(1'b1, 5'd13, 1'b1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    idle();
    step();
    check("pre_rst_inflight", 32'(inflight_cnt), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_inflight", 32'(inflight_cnt), 0);
    check("mid_rst_stallcnt", 32'(stall_cycles), 0);
    drive_id(1'b1, 5'd0, 1'b0, 2'd0, 5'd13, 1'b1, 5'd0, 1'b0);
    check("mid_rst_stall", 32'(stall_ID), 0);
    check("mid_rst_fwd1", 32'(fwd_sel_rs1), 0);

    // Saturation: a chain of VDOTs, each reading its own destination.
    // This gives a pattern of one issue followed by two stalls.
    drive_id(1'b1, 5'd15, 1'b1, 2'd2, 5'd15, 1'b1, 5'd0, 1'b0);
    repeat (10) step();
    check("sat_pre", 32'(stall_cycles), 6);
    step();
    check("sat_max", 32'(stall_cycles), 7);
    repeat (2) step();
    check("sat_hold", 32'(stall_cycles), 7);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
